// File: rtl/cpu_selftest_ctrl.sv
// cpu_selftest_ctrl
//   Self-test controller for the pipelined CPU wrapper. It streams a program
//   into the CPU's unified memory while the CPU is held in reset. It then
//   releases the CPU and watches PC for a finish address. After a fixed drain
//   period it compares selected architectural registers against expected
//   values and reports pass/fail.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   start                pulse; begins a test from IDLE or DONE
//   ld_valid/ld_ready    program byte handshake (ld_addr, ld_data, ld_last)
//   mem_we/addr/wdata    registered write port into CPU memory
//   cpu_rstn             CPU reset, active-low; high only in RUN and DRAIN
//   pc                   CPU program counter
//   fin_addr, timeout,
//   chk_mask, chk_exp    test configuration, sampled on start
//   chk_val              live register values, channel i at [i*DW +: DW]
//   done/pass/fail_vec/
//   timed_out/cycles     result, valid while done is high
//   dbg_state            current controller state, for observation only
//
// Handshake: a program byte transfers on a rising edge where
// ld_valid & ld_ready are both high. ld_valid may be held without a transfer
// and is never required to drop. ld_ready depends only on the controller
// state, never on ld_valid.
//
// SETTLE and DRAIN are expected to be at least 1.
module cpu_selftest_ctrl #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int NUM_CHK = 4,
  parameter int SETTLE  = 2,
  parameter int DRAIN   = 20,
  parameter int TW      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [AW-1:0]         ld_addr,
  input  logic [DW-1:0]         ld_data,
  input  logic                  ld_last,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic                  cpu_rstn,
  input  logic [AW-1:0]         pc,
  input  logic [AW-1:0]         fin_addr,
  input  logic [TW-1:0]         timeout,
  input  logic [NUM_CHK-1:0]    chk_mask,
  input  logic [NUM_CHK*DW-1:0] chk_val,
  input  logic [NUM_CHK*DW-1:0] chk_exp,
  output logic                  done,
  output logic                  pass,
  output logic [NUM_CHK-1:0]    fail_vec,
  output logic                  timed_out,
  output logic [TW-1:0]         cycles,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam int MAXW = (SETTLE > DRAIN) ? SETTLE : DRAIN;
  localparam int CW   = $clog2(MAXW + 1);

  state_t                  state, state_d;
  logic [CW-1:0]           wait_cnt;
  logic [AW-1:0]           fin_q;
  logic [TW-1:0]           timeout_q;
  logic [NUM_CHK-1:0]      mask_q;
  logic [NUM_CHK*DW-1:0]   exp_r;
  logic [NUM_CHK-1:0]      fv;
  logic [TW-1:0]           cyc_inc;
  logic                    accept;
  logic                    take_start;

  assign ld_ready   = (state == S_LOAD);
  assign accept     = ld_valid & ld_ready;
  assign cpu_rstn   = (state == S_RUN) || (state == S_DRAIN);
  assign done       = (state == S_DONE);
  assign dbg_state  = state;
  assign take_start = start && ((state == S_IDLE) || (state == S_DONE));

  // The cycle count saturates instead of wrapping, so a long run without a
  // timeout cannot alias to a small count.
  assign cyc_inc = (cycles == {TW{1'b1}}) ? cycles : cycles + 1'b1;

  always_comb begin
    fv = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      fv[i] = mask_q[i] & (chk_val[i*DW +: DW] != exp_r[i*DW +: DW]);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD;
      S_LOAD:         if (accept && ld_last) state_d = S_SETTLE;
      S_SETTLE:       if (wait_cnt == CW'(SETTLE - 1)) state_d = S_RUN;
      S_RUN: begin
        // A finish wins over a timeout that expires on the same cycle.
        if (pc == fin_q)
          state_d = S_DRAIN;
        else if ((timeout_q != '0) && (cyc_inc >= timeout_q))
          state_d = S_CHECK;
      end
      S_DRAIN:        if (wait_cnt == CW'(DRAIN - 1)) state_d = S_CHECK;
      S_CHECK:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      fin_q     <= '0;
      timeout_q <= '0;
      mask_q    <= '0;
      exp_r     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pass      <= 1'b0;
      fail_vec  <= '0;
      timed_out <= 1'b0;
      cycles    <= '0;
    end else begin
      state  <= state_d;
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= ld_addr;
        mem_wdata <= ld_data;
      end

      // One counter serves both SETTLE and DRAIN; it restarts on every
      // state change.
      if (((state == S_SETTLE) || (state == S_DRAIN)) && (state_d == state))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      if (take_start) begin
        fin_q     <= fin_addr;
        timeout_q <= timeout;
        mask_q    <= chk_mask;
        exp_r     <= chk_exp;
        pass      <= 1'b0;
        fail_vec  <= '0;
        timed_out <= 1'b0;
        cycles    <= '0;
      end

      if (state == S_RUN) begin
        cycles <= cyc_inc;
        if (state_d == S_CHECK) timed_out <= 1'b1;
      end

      if (state == S_CHECK) begin
        fail_vec <= fv;
        pass     <= ~timed_out & ~|fv;
      end
    end
  end

endmodule

// File: tb/tb_cpu_selftest_ctrl.sv
// tb_cpu_selftest_ctrl
//   Self-checking bench for cpu_selftest_ctrl. It runs a table of directed
//   tests with hand-written expectations. It then runs randomized tests whose
//   expectations come from a spec-level reference model, and a hand-written
//   sequence that resets the controller mid-load.
module tb_cpu_selftest_ctrl;

  localparam int AW = 8, DW = 8, NC = 4, SETTLE = 2, DRAIN = 20, TW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic           start = 0, ld_valid = 0, ld_last = 0;
  logic [AW-1:0]  ld_addr = 0, pc = 0, fin_addr = 0;
  logic [DW-1:0]  ld_data = 0;
  logic [TW-1:0]  timeout = 0;
  logic [NC-1:0]  chk_mask = 0;
  logic [NC*DW-1:0] chk_val = 0, chk_exp = 0;
  logic           ld_ready, mem_we, cpu_rstn, done, pass, timed_out;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [NC-1:0]  fail_vec;
  logic [TW-1:0]  cycles;
  logic [2:0]     dbg_state;

  cpu_selftest_ctrl #(.AW(AW), .DW(DW), .NUM_CHK(NC), .SETTLE(SETTLE),
                      .DRAIN(DRAIN), .TW(TW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rstn(cpu_rstn), .pc(pc),
    .fin_addr(fin_addr), .timeout(timeout), .chk_mask(chk_mask),
    .chk_val(chk_val), .chk_exp(chk_exp), .done(done), .pass(pass),
    .fail_vec(fail_vec), .timed_out(timed_out), .cycles(cycles),
    .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: memory writes ----------------
  logic [AW+DW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected mem_we", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("mem_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
        check("mem_wdata", 32'(mem_wdata), 32'(e[DW-1:0]));
      end
    end
  end

  // ---------------- CPU stand-in: PC sequence ----------------
  // run_k counts cycles with the CPU out of reset. The PC hits the finish
  // address on run cycle cur_fin_cycle (0 = never) and loops elsewhere before.
  int            run_k = 0;
  int            cur_fin_cycle = 0;
  logic [AW-1:0] cur_fin = 0;

  always @(negedge clk) begin
    if (ld_ready) begin
      run_k = 0;
      pc    = cur_fin + 8'd1;
    end else if (cpu_rstn) begin
      run_k++;
      if (cur_fin_cycle != 0 && run_k >= cur_fin_cycle)
        pc = cur_fin;
      else
        pc = cur_fin + 8'(1 + (run_k % 5));
    end
  end

  // ---------------- test records ----------------
  typedef struct {
    logic          fixed;       // use the fixed 4-byte program at 10..13
    int            nbytes;
    int            fin_cycle;   // 0 = never finishes
    logic [AW-1:0] fin;
    logic [TW-1:0] tmo;
    logic [NC-1:0] mask;
    logic [31:0]   exp;
    logic [31:0]   val;
    logic          poke;        // pulse start while the CPU runs
    logic          e_pass;
    logic [NC-1:0] e_fv;
    logic          e_to;
    logic [TW-1:0] e_cyc;
  } test_t;

  // Spec-level reference: the outcome follows from when the finish happens
  // relative to the timeout, plus a per-channel comparison.
  task automatic model(inout test_t t);
    if (t.fin_cycle != 0 && (t.tmo == 0 || t.fin_cycle <= int'(t.tmo))) begin
      t.e_cyc = TW'(t.fin_cycle);
      t.e_to  = 1'b0;
    end else begin
      t.e_cyc = t.tmo;
      t.e_to  = 1'b1;
    end
    for (int i = 0; i < NC; i++)
      t.e_fv[i] = t.mask[i] && (t.val[i*8 +: 8] != t.exp[i*8 +: 8]);
    t.e_pass = !t.e_to && (t.e_fv == 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic last);
    int k;
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    for (k = 0; k < 50 && !ld_ready; k++) @(negedge clk);
    check("ld_ready wait", 32'(ld_ready), 32'd1);
    exp_q.push_back({a, d});
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_test(input test_t t, input string tag);
    int n;
    logic [AW-1:0] a;
    @(negedge clk);
    cur_fin = t.fin; cur_fin_cycle = t.fin_cycle;
    fin_addr = t.fin; timeout = t.tmo; chk_mask = t.mask;
    chk_exp = t.exp; chk_val = t.val;
    pulse_start();
    check({tag, " cleared done"}, 32'(done), 32'd0);
    check({tag, " cleared cycles"}, 32'(cycles), 32'd0);
    check({tag, " ld_ready in load"}, 32'(ld_ready), 32'd1);

    a = 8'($urandom_range(0, 200));
    for (int i = 0; i < t.nbytes; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (t.fixed)
        send_byte(8'(10 + i), 8'(8'hAA + 8'h11 * i), i == t.nbytes - 1);
      else
        send_byte(a + 8'(i), 8'($urandom_range(0, 255)), i == t.nbytes - 1);
    end
    check({tag, " ld_ready drop"}, 32'(ld_ready), 32'd0);

    n = 0;
    while (!cpu_rstn && n < 50) begin n++; @(negedge clk); end
    check({tag, " settle cycles"}, 32'(n), 32'(SETTLE));

    // Config inputs change after start; the sampled copies must be used.
    fin_addr = t.fin + 8'd2; timeout = 16'd3;
    chk_mask = ~t.mask; chk_exp = ~t.exp;
    if (t.poke) begin
      @(negedge clk);
      pulse_start();
    end

    n = 0;
    while (!done && n < 3000) begin n++; @(negedge clk); end
    check({tag, " done seen"}, 32'(done), 32'd1);
    check({tag, " pass"}, 32'(pass), 32'(t.e_pass));
    check({tag, " fail_vec"}, 32'(fail_vec), 32'(t.e_fv));
    check({tag, " timed_out"}, 32'(timed_out), 32'(t.e_to));
    check({tag, " cycles"}, 32'(cycles), 32'(t.e_cyc));
    check({tag, " cpu run length"}, 32'(run_k),
          32'(int'(t.e_cyc) + (t.e_to ? 0 : DRAIN)));
    check({tag, " cpu_rstn in done"}, 32'(cpu_rstn), 32'd0);
    check({tag, " writes drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  test_t tbl[8];

  initial begin
    //          fixed n  finc fin    tmo    mask     exp           val          poke pass fv      to cyc
    tbl[0] = '{1'b1, 4, 30, 8'd41, 16'd0,   4'b0001, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 1'b1, 4'b0000, 1'b0, 16'd30};
    tbl[1] = '{1'b0, 3, 30, 8'd41, 16'd0,   4'b0001, 32'h0000_00FF, 32'h0000_00FE, 1'b1, 1'b0, 4'b0001, 1'b0, 16'd30};
    tbl[2] = '{1'b0, 2, 0,  8'd41, 16'd100, 4'b0001, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 1'b0, 4'b0000, 1'b1, 16'd100};
    tbl[3] = '{1'b0, 2, 100, 8'd41, 16'd100, 4'b0001, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 1'b1, 4'b0000, 1'b0, 16'd100};
    tbl[4] = '{1'b0, 1, 0,  8'd77, 16'd7,   4'b1010, 32'h4433_2211, 32'h0033_2A11, 1'b0, 1'b0, 4'b1010, 1'b1, 16'd7};
    tbl[5] = '{1'b0, 5, 1,  8'd5,  16'd5,   4'b0000, 32'h4433_2211, 32'hBBCC_DDEE, 1'b0, 1'b1, 4'b0000, 1'b0, 16'd1};
    tbl[6] = '{1'b0, 2, 6,  8'd200, 16'd5,  4'b1111, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 4'b0000, 1'b1, 16'd5};
    tbl[7] = '{1'b0, 1, 1,  8'd0,  16'd1,   4'b1111, 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst ld_ready", 32'(ld_ready), 0);
    check("rst mem_we", 32'(mem_we), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst mem_wdata", 32'(mem_wdata), 0);
    check("rst cpu_rstn", 32'(cpu_rstn), 0);
    check("rst done", 32'(done), 0);
    check("rst pass", 32'(pass), 0);
    check("rst fail_vec", 32'(fail_vec), 0);
    check("rst timed_out", 32'(timed_out), 0);
    check("rst cycles", 32'(cycles), 0);
    rstn = 1'b1;

    // start is ignored while idle without a pulse, and pc does nothing idle
    repeat (3) @(negedge clk);
    check("idle ld_ready", 32'(ld_ready), 0);

    for (int i = 0; i < 8; i++) run_test(tbl[i], $sformatf("tbl%0d", i));

    // Reset during LOAD after two bytes: abort at once, then rerun cleanly.
    @(negedge clk);
    pulse_start();
    send_byte(8'd50, 8'h11, 1'b0);
    send_byte(8'd51, 8'h22, 1'b0);
    ld_valid = 1'b1; ld_addr = 8'd52; ld_data = 8'h33; ld_last = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    check("abort mem_we", 32'(mem_we), 0);
    check("abort cpu_rstn", 32'(cpu_rstn), 0);
    check("abort ld_ready", 32'(ld_ready), 0);
    check("abort done", 32'(done), 0);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("abort no writes", 32'(exp_q.size()), 0);
    run_test(tbl[5], "after_abort");

    // Randomized tests against the reference model
    for (int r = 0; r < 12; r++) begin
      test_t t;
      int mode;
      mode        = $urandom_range(0, 2);
      t.fixed     = 1'b0;
      t.nbytes    = $urandom_range(1, 6);
      t.fin       = 8'($urandom_range(0, 255));
      t.fin_cycle = (mode == 1) ? 0 : $urandom_range(1, 60);
      t.tmo       = (mode == 0) ? 16'd0 : 16'($urandom_range(1, 60));
      t.mask      = 4'($urandom_range(0, 15));
      t.exp       = $urandom;
      t.val       = t.exp;
      for (int i = 0; i < NC; i++)
        if ($urandom_range(0, 2) == 0) t.val[i*8 +: 8] = t.val[i*8 +: 8] ^ 8'($urandom_range(1, 255));
      t.poke      = 1'($urandom_range(0, 1));
      model(t);
      run_test(t, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
